// File: rtl/ring_ptr_pkg.sv
// rtl/ring_ptr_pkg.sv - shared parameters and FSM state encoding for ring_ptr_ctrl
package ring_ptr_pkg;

  localparam int ADDR_W = 7;
  localparam int LANES  = 4;
  localparam int CNT_W  = 3;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PTR_W  = ADDR_W + 1;

  // Plain constants rather than an enum so the encoding stays fixed for
  // older tools and netlist comparison.
  typedef logic [0:0] state_t;
  localparam state_t RUN   = 1'b0;
  localparam state_t DRAIN = 1'b1;

endpackage

// File: rtl/lane_ptr_gen.sv
// rtl/lane_ptr_gen.sv - base write pointer to per-lane pointers, wrap bits and enables
module lane_ptr_gen #(
  parameter int ADDR_W = 7,
  parameter int LANES  = 4,
  parameter int CNT_W  = 3
) (
  input  logic [ADDR_W:0]             i_base,
  input  logic                        i_fire,
  input  logic [CNT_W-1:0]            i_count,
  output logic [LANES*(ADDR_W+1)-1:0] o_lane_ptr,
  output logic [LANES-1:0]            o_lane_wrap,
  output logic [LANES-1:0]            o_lane_en
);

  localparam int PW = ADDR_W + 1;

  // Each lane is base+i; the add wraps naturally at PW bits, which toggles
  // the wrap bit for lanes that run past the top of the buffer.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] w_ptr;
    assign w_ptr                    = i_base + PW'(i);
    assign o_lane_ptr[i*PW +: PW]   = w_ptr;
    assign o_lane_wrap[i]           = w_ptr[PW-1];
    assign o_lane_en[i]             = i_fire & (CNT_W'(i) < i_count);
  end

endmodule

// File: rtl/ring_ptr_ctrl.sv
// rtl/ring_ptr_ctrl.sv - multi-lane circular buffer pointer, occupancy and drain controller
module ring_ptr_ctrl #(
  parameter int ADDR_W = ring_ptr_pkg::ADDR_W,
  parameter int LANES  = ring_ptr_pkg::LANES,
  parameter int CNT_W  = ring_ptr_pkg::CNT_W
) (
  input  logic                        CLK,
  input  logic                        ASYNCRESETN,
  input  logic                        push_valid,
  input  logic [CNT_W-1:0]            push_count,
  output logic                        push_ready,
  input  logic                        pop_valid,
  input  logic [CNT_W-1:0]            pop_count,
  output logic                        pop_ready,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic [LANES*(ADDR_W+1)-1:0] wr_lane_ptr,
  output logic [LANES-1:0]            wr_lane_wrap,
  output logic [LANES-1:0]            wr_lane_en,
  output logic [ADDR_W:0]             rd_ptr,
  output logic [ADDR_W:0]             occupancy,
  output logic                        full,
  output logic                        empty
);

  import ring_ptr_pkg::*;

  localparam int PW      = ADDR_W + 1;
  localparam int L_DEPTH = 2 ** ADDR_W;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_occ;
  state_t        r_state;

  logic [PW-1:0] w_space;
  logic          w_push_fire;
  logic          w_pop_fire;
  logic [PW-1:0] w_push_add;
  logic [PW-1:0] w_pop_sub;

  // Handshakes use only registered occupancy, so a same-cycle push never
  // funds a pop and a same-cycle pop never frees room for a push.
  assign w_space     = PW'(L_DEPTH) - r_occ;
  assign push_ready  = (r_state == RUN) & (push_count <= CNT_W'(LANES)) &
                       (w_space >= PW'(push_count));
  assign pop_ready   = (pop_count <= CNT_W'(LANES)) & (r_occ >= PW'(pop_count));
  assign w_push_fire = push_valid & push_ready;
  assign w_pop_fire  = pop_valid & pop_ready;
  assign w_push_add  = w_push_fire ? PW'(push_count) : '0;
  assign w_pop_sub   = w_pop_fire  ? PW'(pop_count)  : '0;

  // Pointers and occupancy advance by the accepted counts; pointer adds wrap at PW bits.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_add;
      r_rd_ptr <= r_rd_ptr + w_pop_sub;
      r_occ    <= r_occ + w_push_add - w_pop_sub;
    end
  end

  // RUN/DRAIN: a flush blocks pushes until the buffer has been popped empty.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     if (flush_req)      r_state <= DRAIN;
        DRAIN:   if (r_occ == '0)    r_state <= RUN;
        default:                     r_state <= RUN;
      endcase
    end
  end

  // Pulses exactly in the DRAIN->RUN transition cycle.
  assign flush_done = (r_state == DRAIN) & (r_occ == '0);

  assign full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &
                 (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  assign rd_ptr    = r_rd_ptr;
  assign occupancy = r_occ;

  lane_ptr_gen #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) u_lane_ptr_gen (
    .i_base      (r_wr_ptr),
    .i_fire      (w_push_fire),
    .i_count     (push_count),
    .o_lane_ptr  (wr_lane_ptr),
    .o_lane_wrap (wr_lane_wrap),
    .o_lane_en   (wr_lane_en)
  );

endmodule

// File: tb/tb_ring_ptr_ctrl.sv
// tb/tb_ring_ptr_ctrl.sv - directed self-checking bench for ring_ptr_ctrl
module tb_ring_ptr_ctrl;

  logic        CLK = 1'b0;
  logic        ASYNCRESETN;
  logic        push_valid;
  logic [2:0]  push_count;
  logic        push_ready;
  logic        pop_valid;
  logic [2:0]  pop_count;
  logic        pop_ready;
  logic        flush_req;
  logic        flush_done;
  logic [31:0] wr_lane_ptr;
  logic [3:0]  wr_lane_wrap;
  logic [3:0]  wr_lane_en;
  logic [7:0]  rd_ptr;
  logic [7:0]  occupancy;
  logic        full;
  logic        empty;

  int vectors = 0;
  int errors  = 0;

  ring_ptr_ctrl dut (
    .CLK          (CLK),
    .ASYNCRESETN  (ASYNCRESETN),
    .push_valid   (push_valid),
    .push_count   (push_count),
    .push_ready   (push_ready),
    .pop_valid    (pop_valid),
    .pop_count    (pop_count),
    .pop_ready    (pop_ready),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .wr_lane_ptr  (wr_lane_ptr),
    .wr_lane_wrap (wr_lane_wrap),
    .wr_lane_en   (wr_lane_en),
    .rd_ptr       (rd_ptr),
    .occupancy    (occupancy),
    .full         (full),
    .empty        (empty)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] lane(input int i);
    return wr_lane_ptr[i*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [2:0] pc,
                       input logic qv, input logic [2:0] qc, input logic fr);
    push_valid = pv;
    push_count = pc;
    pop_valid  = qv;
    pop_count  = qc;
    flush_req  = fr;
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    ASYNCRESETN = 1'b1;
    tick();

    // reset state
    chk("rst_occ", occupancy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_lane0", lane(0), 8'h00);
    chk("rst_lane3", lane(3), 8'h03);
    chk("rst_rdptr", rd_ptr, 0);
    chk("rst_flush_done", flush_done, 0);

    // build occupancy 9, then async reset mid-cycle
    drive(1, 4, 0, 0, 0); tick();
    drive(1, 4, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_occ", occupancy, 9);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_empty", empty, 1);
    chk("arst_lane0", lane(0), 8'h00);
    chk("arst_lane3", lane(3), 8'h03);
    chk("arst_rdptr", rd_ptr, 0);
    #2;
    ASYNCRESETN = 1'b1;
    tick();
    chk("arst_hold_occ", occupancy, 0);

    // fill to full with push 4 x 32
    for (int i = 0; i < 32; i++) begin
      drive(1, 4, 0, 0, 0);
      #1;
      if (i == 0) chk("fill_en", wr_lane_en, 4'hF);
      tick();
    end
    drive(1, 1, 0, 0, 0);
    #1;
    chk("fill_occ", occupancy, 128);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    chk("fill_wrptr", lane(0), 8'h80);
    chk("fill_push_rdy", push_ready, 0);
    chk("fill_en_blocked", wr_lane_en, 4'h0);
    drive(0, 1, 1, 1, 0);
    #1;
    chk("fill_pop_rdy", pop_ready, 1);
    chk("fill_no_credit", push_ready, 0);
    tick();
    drive(0, 1, 0, 0, 0);
    #1;
    chk("fill_pop_occ", occupancy, 127);
    chk("fill_pop_rdptr", rd_ptr, 8'h01);
    chk("fill_push_rdy_back", push_ready, 1);
    chk("fill_not_full", full, 0);

    // lane wrap: reset, then move wr_ptr to 0xFE
    ASYNCRESETN = 1'b0;
    #2;
    ASYNCRESETN = 1'b1;
    drive(1, 2, 0, 0, 0); tick();
    drive(1, 4, 0, 0, 0); tick();
    for (int i = 0; i < 62; i++) begin
      drive(1, 4, 1, 4, 0);
      tick();
    end
    drive(1, 4, 0, 0, 0);
    #1;
    chk("wrap_occ_pre", occupancy, 6);
    chk("wrap_rdptr_pre", rd_ptr, 8'hF8);
    chk("wrap_lane0", lane(0), 8'hFE);
    chk("wrap_lane1", lane(1), 8'hFF);
    chk("wrap_lane2", lane(2), 8'h00);
    chk("wrap_lane3", lane(3), 8'h01);
    chk("wrap_bits", wr_lane_wrap, 4'b0011);
    chk("wrap_en", wr_lane_en, 4'hF);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("wrap_wrptr_next", lane(0), 8'h02);
    chk("wrap_occ", occupancy, 10);

    // simultaneous push 3 / pop 2 at occupancy 10
    drive(1, 3, 1, 2, 0);
    #1;
    chk("sim_push_rdy", push_ready, 1);
    chk("sim_pop_rdy", pop_ready, 1);
    chk("sim_en", wr_lane_en, 4'b0111);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    chk("sim_occ", occupancy, 11);
    chk("sim_rdptr", rd_ptr, 8'hFA);
    chk("sim_wrptr", lane(0), 8'h05);

    // drain from occupancy 6
    drive(0, 0, 1, 4, 0); tick();
    drive(0, 0, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 1);
    #1;
    chk("drain_occ_pre", occupancy, 6);
    tick();
    drive(1, 1, 1, 2, 1);
    #1;
    chk("drain_push_rdy", push_ready, 0);
    chk("drain_en", wr_lane_en, 4'h0);
    chk("drain_done0", flush_done, 0);
    tick();
    drive(1, 1, 1, 2, 0);
    #1;
    chk("drain_occ4", occupancy, 4);
    chk("drain_done1", flush_done, 0);
    tick();
    drive(1, 1, 1, 2, 0);
    #1;
    chk("drain_occ2", occupancy, 2);
    tick();
    drive(0, 1, 0, 0, 0);
    #1;
    chk("drain_occ0", occupancy, 0);
    chk("drain_done_pulse", flush_done, 1);
    chk("drain_push_rdy_last", push_ready, 0);
    tick();
    #1;
    chk("drain_done_clr", flush_done, 0);
    chk("drain_run_push_rdy", push_ready, 1);
    chk("drain_rdptr", rd_ptr, 8'h05);
    chk("drain_empty", empty, 1);

    // illegal / limit cases at occupancy 1
    drive(1, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 2, 0);
    #1;
    chk("lim_occ1", occupancy, 1);
    chk("lim_pop_rdy", pop_ready, 0);
    tick();
    drive(1, 5, 0, 0, 0);
    #1;
    chk("lim_pop_rdptr", rd_ptr, 8'h05);
    chk("lim_pop_occ", occupancy, 1);
    chk("lim_push5_rdy", push_ready, 0);
    chk("lim_push5_en", wr_lane_en, 4'h0);
    tick();
    drive(1, 0, 0, 0, 0);
    #1;
    chk("lim_push5_wrptr", lane(0), 8'h06);
    chk("lim_push5_occ", occupancy, 1);
    chk("zero_push_rdy", push_ready, 1);
    chk("zero_push_en", wr_lane_en, 4'h0);
    tick();
    drive(0, 0, 1, 5, 0);
    #1;
    chk("zero_wrptr", lane(0), 8'h06);
    chk("lim_pop5_rdy", pop_ready, 0);
    tick();

    // flush with empty buffer: one DRAIN cycle then flush_done
    drive(0, 0, 1, 1, 0); tick();
    drive(0, 0, 0, 0, 1);
    #1;
    chk("eflush_occ", occupancy, 0);
    chk("eflush_done_run", flush_done, 0);
    tick();
    drive(0, 1, 0, 0, 0);
    #1;
    chk("eflush_done", flush_done, 1);
    chk("eflush_push_rdy", push_ready, 0);
    tick();
    #1;
    chk("eflush_done_clr", flush_done, 0);
    chk("eflush_push_rdy_back", push_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
